mul_sequencer: RTL and testbench

- Multi-cycle controller for MUL/MLA in the multicycle ARM core.
- The register file has only two read ports, but MLA needs three source operands. This block sequences the operand reads, runs a 1-bit-per-cycle shift-add multiply, and issues a single register-file write-back.
- It sits beside the main control FSM. The main FSM pulses start on decode of a multiply and stalls until done.

---
 rtl/mul_seq_pkg.sv | 43 ++++
 rtl/mul_shift_add_dp.sv | 51 +++++
 rtl/mul_sequencer.sv | 110 +++++++++++
 tb/tb_mul_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the MUL/MLA sequencer: state codes, instruction
// field positions and a field decode helper.
package mul_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t RD_OPS = 3'd1;
   localparam state_t RD_ACC = 3'd2;
   localparam state_t MUL    = 3'd3;
   localparam state_t WB     = 3'd4;

   localparam int RD_HI   = 19;
   localparam int RD_LO   = 16;
   localparam int RA_HI   = 15;
   localparam int RA_LO   = 12;
   localparam int RS_HI   = 11;
   localparam int RS_LO   = 8;
   localparam int RM_HI   = 3;
   localparam int RM_LO   = 0;
   localparam int ACC_BIT = 21;

   localparam logic [3:0] PC_REG = 4'd15;

   typedef struct packed {
      logic       acc;
      logic [3:0] rd;
      logic [3:0] ra;
      logic [3:0] rs;
      logic [3:0] rm;
   } mul_fields_t;

   function automatic mul_fields_t decode_fields(input logic [31:0] instr);
      mul_fields_t f;
      f.acc = instr[ACC_BIT];
      f.rd  = instr[RD_HI:RD_LO];
      f.ra  = instr[RA_HI:RA_LO];
      f.rs  = instr[RS_HI:RS_LO];
      f.rm  = instr[RM_HI:RM_LO];
      return f;
   endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: holds multiplicand, multiplier, running
// product and iteration count; one multiplier bit is retired per step.
module mul_shift_add_dp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             acc_load,
   input  logic             step,
   input  logic [WIDTH-1:0] rd1,
   input  logic [WIDTH-1:0] rd2,
   output logic [WIDTH-1:0] prod,
   output logic             last,
   output logic             zero
);
   import mul_seq_pkg::*;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplr;
   logic [CW-1:0]    count;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would chain prod/mcand/mplr updates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand <= '0;
         mplr  <= '0;
         prod  <= '0;
         count <= '0;
      end else if (load) begin
         mcand <= rd1;
         mplr  <= rd2;
         prod  <= '0;
         count <= '0;
      end else if (acc_load) begin
         prod  <= rd1;
      end else if (step) begin
         if (mplr[0]) prod <= prod + mcand;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         count <= count + 1'b1;
      end
   end

   assign last = (count == CW'(WIDTH - 1));
   assign zero = (mplr == '0);

endmodule

// File: rtl/mul_sequencer.sv
// MUL/MLA controller: sequences operand reads over two register-file ports,
// runs the shift-add datapath and issues one write-back.
// Optional early termination on a zero multiplier: MUL_SEQ_EARLY_TERM_EN.
module mul_sequencer #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [31:0]           instr,
   output logic [REG_ADDR_W-1:0] ra1,
   output logic [REG_ADDR_W-1:0] ra2,
   input  logic [WIDTH-1:0]      rd1,
   input  logic [WIDTH-1:0]      rd2,
   output logic                  we,
   output logic [REG_ADDR_W-1:0] wa,
   output logic [WIDTH-1:0]      wd,
   output logic                  busy,
   output logic                  done
);
   import mul_seq_pkg::*;

   state_t      state_q;
   state_t      state_d;
   mul_fields_t f_q;

   logic             dp_load;
   logic             dp_acc_load;
   logic             dp_step;
   logic             dp_exit;
   logic [WIDTH-1:0] dp_prod;
   logic             dp_last;
   logic             dp_zero;

   logic unused_instr;
   assign unused_instr = ^{instr[31:22], instr[20], instr[7:4]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         f_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) f_q <= decode_fields(instr);
      end
   end

   assign dp_load     = (state_q == RD_OPS);
   assign dp_acc_load = (state_q == RD_ACC);

`ifdef MUL_SEQ_EARLY_TERM_EN
   // An exhausted multiplier cannot change the product, so stop stepping.
   assign dp_step = (state_q == MUL) && !dp_zero;
   assign dp_exit = dp_last || dp_zero;
`else
   logic unused_zero;
   assign unused_zero = dp_zero;
   assign dp_step = (state_q == MUL);
   assign dp_exit = dp_last;
`endif

   // NOTE: state_d gets a default before the case so every path assigns it
   // and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RD_OPS;
         RD_OPS:  state_d = f_q.acc ? RD_ACC : MUL;
         RD_ACC:  state_d = MUL;
         MUL:     if (dp_exit) state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ra1 = '0;
      ra2 = '0;
      case (state_q)
         RD_OPS: begin
            ra1 = REG_ADDR_W'(f_q.rm);
            ra2 = REG_ADDR_W'(f_q.rs);
         end
         RD_ACC: ra1 = REG_ADDR_W'(f_q.ra);
         default: ;
      endcase
   end

   // Writes to the PC are dropped; done still completes the handshake.
   assign done = (state_q == WB);
   assign we   = done && (f_q.rd != PC_REG);
   assign wa   = done ? REG_ADDR_W'(f_q.rd) : '0;
   assign wd   = done ? dp_prod : '0;
   assign busy = (state_q != IDLE);

   mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .reset    (reset),
      .load     (dp_load),
      .acc_load (dp_acc_load),
      .step     (dp_step),
      .rd1      (rd1),
      .rd2      (rd2),
      .prod     (dp_prod),
      .last     (dp_last),
      .zero     (dp_zero)
   );

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed vector table, busy/reset
// corner sequences and randomized operations against an arithmetic model.
module tb_mul_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] instr;
   logic [3:0]  ra1;
   logic [3:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        we;
   logic [3:0]  wa;
   logic [31:0] wd;
   logic        busy;
   logic        done;

   logic [31:0] regs [16];
   logic        tb_we;
   logic [3:0]  tb_wa;
   logic [31:0] tb_wd;

   int n_checks = 0;
   int n_fail   = 0;

   mul_sequencer #(.WIDTH(32), .REG_ADDR_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .instr (instr),
      .ra1   (ra1),
      .ra2   (ra2),
      .rd1   (rd1),
      .rd2   (rd2),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file environment: combinational reads, DUT write has priority.
   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];
   always @(posedge clk) begin
      if (we) regs[wa] <= wd;
      else if (tb_we) regs[tb_wa] <= tb_wd;
   end

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] vm;
      logic [31:0] vs;
      logic [31:0] va;
      logic [31:0] exp_wd;
      int          lat;
      logic        we_exp;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_reg(input logic [3:0] a, input logic [31:0] v);
      tb_we = 1'b1;
      tb_wa = a;
      tb_wd = v;
      @(posedge clk); #1;
      tb_we = 1'b0;
   endtask

   // Number of MUL-state cycles the multiplier value implies.
   function automatic int mul_cycles(input logic [31:0] m);
`ifdef MUL_SEQ_EARLY_TERM_EN
      int h = -1;
      for (int i = 0; i < 32; i++) if (m[i]) h = i;
      if (h < 0) return 1;
      return (h + 2 > 32) ? 32 : h + 2;
`else
      return 32 + 0 * int'(m[0]);
`endif
   endfunction

   task automatic run_op(input string nm, input logic [31:0] ins, input logic [31:0] exp_wd,
                         input int exp_lat, input logic exp_we, input bit inject);
      int          cyc = 0;
      int          we_cnt = 0;
      bit          busy_ok = 1'b1;
      bit          seen_done = 1'b0;
      logic [31:0] r15_before;
      logic [3:0]  rd;
      rd = ins[19:16];
      r15_before = regs[15];
      instr = ins;
      start = 1'b1;
      while (!seen_done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1 || (inject && cyc == 6)) start = 1'b0;
         if (inject && cyc == 5) start = 1'b1;
         if (cyc == 1) begin
            check({nm, "_ra1_ops"}, ra1, ins[3:0]);
            check({nm, "_ra2_ops"}, ra2, ins[11:8]);
         end
         if (cyc == 2 && ins[21]) begin
            check({nm, "_ra1_acc"}, ra1, ins[15:12]);
            check({nm, "_ra2_acc"}, ra2, 0);
         end
         if (!busy) busy_ok = 1'b0;
         we_cnt += int'(we);
         if (done) seen_done = 1'b1;
      end
      check({nm, "_done_seen"}, seen_done, 1);
      if (!seen_done) begin
         start = 1'b0;
         return;
      end
      check({nm, "_latency"}, cyc, exp_lat);
      check({nm, "_wd"}, wd, exp_wd);
      check({nm, "_wa"}, wa, rd);
      check({nm, "_we"}, we, exp_we);
      check({nm, "_busy_span"}, busy_ok, 1);
      if (inject) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      we_cnt += int'(we);
      check({nm, "_idle_after"}, {busy, done}, 0);
      check({nm, "_we_pulses"}, we_cnt, int'(exp_we));
      if (exp_we) check({nm, "_regfile"}, regs[rd], exp_wd);
      else        check({nm, "_pc_kept"}, regs[15], r15_before);
   endtask

   initial begin
      logic [31:0] ins;
      logic [31:0] a, s, m, exp;
      int          lat;
      int          we_cnt;
      logic [31:0] r7_before;

      reset = 1'b1;
      start = 1'b0;
      instr = '0;
      tb_we = 1'b0;
      tb_wa = '0;
      tb_wd = '0;
      #1;
      check("reset_outs", {ra1, ra2, we, wa, wd, busy, done}, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("idle_outs", {ra1, ra2, we, wa, wd, busy, done}, 0);
      for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);

      vecs[0] = '{32'h0002_0403, 32'd7, 32'd6, 32'd0, 32'd42, 34, 1'b1};
      vecs[1] = '{32'h0025_6201, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'h0000_0003, 35, 1'b1};
      vecs[2] = '{32'h000F_0403, 32'd3, 32'd4, 32'd0, 32'd12, 34, 1'b0};
`ifdef MUL_SEQ_EARLY_TERM_EN
      vecs[3] = '{32'h0008_0A09, 32'h1234, 32'd0, 32'd0, 32'd0, 3, 1'b1};
      vecs[4] = '{32'h0008_0A09, 32'd5, 32'd1, 32'd0, 32'd5, 4, 1'b1};
`else
      vecs[3] = '{32'h0008_0A09, 32'h1234, 32'd0, 32'd0, 32'd0, 34, 1'b1};
      vecs[4] = '{32'h0008_0A09, 32'd5, 32'd1, 32'd0, 32'd5, 34, 1'b1};
`endif
      vecs[5] = '{32'h0021_1101, 32'd7, 32'd7, 32'd7, 32'd56, 35, 1'b1};
      vecs[6] = '{32'h000B_0D0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 34, 1'b1};

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].ins[21]) set_reg(vecs[i].ins[15:12], vecs[i].va);
         set_reg(vecs[i].ins[11:8], vecs[i].vs);
         set_reg(vecs[i].ins[3:0], vecs[i].vm);
         run_op($sformatf("vec%0d", i), vecs[i].ins, vecs[i].exp_wd, vecs[i].lat,
                vecs[i].we_exp, 1'b0);
      end

      // start pulsed mid-operation and in the WB cycle must be ignored
      set_reg(4'd3, 32'd7);
      set_reg(4'd4, 32'd6);
      run_op("busy_ign", 32'h0002_0403, 32'd42, 34, 1'b1, 1'b1);

      // reset in MUL cycle 10 aborts without a write
      set_reg(4'd7, 32'hDEAD_BEEF);
      set_reg(4'd3, 32'd3);
      set_reg(4'd4, 32'd3);
      r7_before = regs[7];
      instr = 32'h0007_0403;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_outs", {ra1, ra2, we, wa, wd, busy, done}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      we_cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         we_cnt += int'(we);
      end
      check("abort_no_we", we_cnt, 0);
      check("abort_reg_kept", regs[7], r7_before);
      run_op("post_reset", 32'h0007_0403, 32'd9, 34, 1'b1, 1'b0);

      for (int n = 0; n < 20; n++) begin
         ins = $urandom;
         if (ins[21]) set_reg(ins[15:12], $urandom);
         set_reg(ins[11:8], ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom);
         set_reg(ins[3:0], $urandom);
         a   = ins[21] ? regs[ins[15:12]] : 32'd0;
         s   = regs[ins[11:8]];
         m   = regs[ins[3:0]];
         exp = m * s + a;
         lat = 2 + int'(ins[21]) + mul_cycles(s);
         run_op($sformatf("rnd%0d", n), ins, exp, lat, ins[19:16] != 4'd15, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
